// File: rtl/mmcm_reset_sequencer_pkg.sv
// Shared definitions for the MMCM / IDELAYCTRL reset sequencer:
// state encodings, default timing constants and width helpers.
package mmcm_reset_sequencer_pkg;

  // Sequencer states; encodings are visible on the debug state port.
  typedef enum logic [2:0] {
    S_RESET_MMCM  = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_STABLE      = 3'd2,
    S_IDELAY_RST  = 3'd3,
    S_WAIT_IDELAY = 3'd4,
    S_RUN         = 3'd5,
    S_FAULT       = 3'd6
  } seq_state_e;

  localparam int unsigned STATE_W = 3;

  // Default timing, in sys_clk cycles.
  localparam int unsigned DEF_RST_PULSE_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT     = 65536;
  localparam int unsigned DEF_STABLE_CYCLES    = 65536;
  localparam int unsigned DEF_IDELAY_TIMEOUT   = 4096;
  localparam int unsigned DEF_MAX_RETRIES      = 3;
  localparam int unsigned DEF_SYNC_STAGES      = 2;

  // Largest of the four count parameters; sizes the shared timer.
  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold 0..n, never less than one.
  function automatic int unsigned count_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/mmcm_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports: clk (destination clock), rst (async active-high, clears chain to 0),
//        d (asynchronous input), q (synchronized output, STAGES cycles latency).
module mmcm_reset_sequencer_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; only the first flop may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Closed-loop clock/reset controller running on the free-running input clock.
// Pulses MMCM RST, waits for lock (timeout + retry), requires a stable lock
// window, pulses IDELAYCTRL RST, waits for RDY and then releases system reset.
// Ports:
//   sys_clk, sys_rst      free-running clock, async active-high reset
//   mmcm_locked           MMCM LOCKED (async, synchronized internally)
//   idelay_rdy            IDELAYCTRL RDY (async, synchronized internally)
//   force_reset           one-cycle synchronous restart request
//   mmcm_rst, idelay_rst  reset pulses to the MMCM / IDELAYCTRL
//   rst_out, ready        system reset (low only in RUN) and run indicator
//   fault                 sticky failure flag
//   retry_count           MMCM retries consumed in the current attempt
//   state                 current sequencer state (debug)
module mmcm_reset_sequencer
  import mmcm_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int unsigned IDELAY_TIMEOUT   = DEF_IDELAY_TIMEOUT,
  parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  localparam int unsigned RETRY_W         = count_width(MAX_RETRIES)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               mmcm_locked,
  input  logic               idelay_rdy,
  input  logic               force_reset,
  output logic               mmcm_rst,
  output logic               idelay_rst,
  output logic               rst_out,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned TIMER_MAX = max_of4(RST_PULSE_CYCLES, LOCK_TIMEOUT,
                                              STABLE_CYCLES, IDELAY_TIMEOUT);
  localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  seq_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lock_s, rdy_s;
  logic               retry_req;
  logic               mmcm_rst_d, idelay_rst_d, rst_out_d, ready_d, fault_d;

  // Synchronize the asynchronous status inputs before any use.
  mmcm_reset_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (mmcm_locked),
    .q   (lock_s)
  );

  mmcm_reset_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (idelay_rdy),
    .q   (rdy_s)
  );

  // State, timer, retry counter and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_RESET_MMCM;
      timer_q     <= '0;
      retry_count <= '0;
      mmcm_rst    <= 1'b1;
      idelay_rst  <= 1'b1;
      rst_out     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_count <= retry_d;
      mmcm_rst    <= mmcm_rst_d;
      idelay_rst  <= idelay_rst_d;
      rst_out     <= rst_out_d;
      ready       <= ready_d;
      fault       <= fault_d;
    end
  end

  // Next-state, timer and output decode. Priority: force_reset > lock loss > counts.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_count;
    retry_req = 1'b0;
    // Timer saturates rather than wrapping in long-lived states.
    timer_d   = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);

    if (force_reset) begin
      state_d = S_RESET_MMCM;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_MMCM: begin
          if (timer_q == TIMER_W'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) state_d = S_STABLE;
          else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) retry_req = 1'b1;
        end
        S_STABLE: begin
          if (!lock_s) retry_req = 1'b1;
          else if (timer_q == TIMER_W'(STABLE_CYCLES - 1)) state_d = S_IDELAY_RST;
        end
        S_IDELAY_RST: begin
          if (timer_q == TIMER_W'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT_IDELAY;
        end
        S_WAIT_IDELAY: begin
          if (!lock_s) begin
            retry_req = 1'b1;
          end else if (rdy_s) begin
            state_d = S_RUN;
            retry_d = '0;
          end else if (timer_q == TIMER_W'(IDELAY_TIMEOUT - 1)) begin
            state_d = S_FAULT;
          end
        end
        S_RUN: begin
          // Lock loss in RUN starts a fresh attempt with a full retry budget.
          if (!lock_s) begin
            state_d = S_RESET_MMCM;
            retry_d = '0;
          end else if (!rdy_s) begin
            state_d = S_IDELAY_RST;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RESET_MMCM;
      endcase

      if (retry_req) begin
        if (retry_count == RETRY_W'(MAX_RETRIES)) begin
          state_d = S_FAULT;
        end else begin
          retry_d = retry_count + RETRY_W'(1);
          state_d = S_RESET_MMCM;
        end
      end
    end

    // A forced restart also restarts the MMCM pulse if already in RESET_MMCM.
    if (force_reset || (state_d != state_q)) timer_d = '0;

    mmcm_rst_d   = (state_d == S_RESET_MMCM);
    idelay_rst_d = (state_d inside {S_RESET_MMCM, S_WAIT_LOCK, S_STABLE, S_IDELAY_RST, S_FAULT});
    rst_out_d    = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
  end

  assign state = state_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Testbench for mmcm_reset_sequencer: directed scenarios with hand-computed
// cycle numbers plus randomized stimulus against a behavioural reference.
module tb_mmcm_reset_sequencer;

  localparam int P_RST  = 4;
  localparam int P_LT   = 32;
  localparam int P_ST   = 16;
  localparam int P_IT   = 32;
  localparam int P_MR   = 2;
  localparam int P_SYNC = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       mmcm_locked = 1'b0;
  logic       idelay_rdy = 1'b0;
  logic       force_reset = 1'b0;
  logic       mmcm_rst, idelay_rst, rst_out, ready, fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mmcm_reset_sequencer #(
    .RST_PULSE_CYCLES (P_RST),
    .LOCK_TIMEOUT     (P_LT),
    .STABLE_CYCLES    (P_ST),
    .IDELAY_TIMEOUT   (P_IT),
    .MAX_RETRIES      (P_MR),
    .SYNC_STAGES      (P_SYNC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .mmcm_locked (mmcm_locked),
    .idelay_rdy  (idelay_rdy),
    .force_reset (force_reset),
    .mmcm_rst    (mmcm_rst),
    .idelay_rst  (idelay_rst),
    .rst_out     (rst_out),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .state       (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int k;
    k = 0;
    while (int'(state) != s && k < lim) begin
      cyc();
      k++;
    end
    check(nm, 32'(state), 32'(s));
  endtask

  // Reference model: phase number, cycles spent in phase, retries used, and
  // raw input history standing in for the synchronizer delay.
  int m_st, m_cnt, m_retry, m_nxt;
  bit m_ls, m_rs, m_req;
  bit lpipe[P_SYNC];
  bit rpipe[P_SYNC];

  task automatic model_step();
    if (sys_rst) begin
      m_st = 0; m_cnt = 0; m_retry = 0;
      for (int i = 0; i < P_SYNC; i++) begin lpipe[i] = 1'b0; rpipe[i] = 1'b0; end
      return;
    end
    m_ls = lpipe[P_SYNC-1];
    m_rs = rpipe[P_SYNC-1];
    for (int i = P_SYNC - 1; i > 0; i--) begin lpipe[i] = lpipe[i-1]; rpipe[i] = rpipe[i-1]; end
    lpipe[0] = mmcm_locked;
    rpipe[0] = idelay_rdy;
    m_nxt = m_st;
    m_req = 1'b0;
    if (force_reset) begin
      m_nxt = 0; m_retry = 0;
    end else begin
      case (m_st)
        0: if (m_cnt + 1 == P_RST) m_nxt = 1;
        1: if (m_ls) m_nxt = 2; else if (m_cnt + 1 == P_LT) m_req = 1'b1;
        2: if (!m_ls) m_req = 1'b1; else if (m_cnt + 1 == P_ST) m_nxt = 3;
        3: if (m_cnt + 1 == P_RST) m_nxt = 4;
        4: begin
          if (!m_ls) m_req = 1'b1;
          else if (m_rs) begin m_nxt = 5; m_retry = 0; end
          else if (m_cnt + 1 == P_IT) m_nxt = 6;
        end
        5: if (!m_ls) begin m_nxt = 0; m_retry = 0; end else if (!m_rs) m_nxt = 3;
        default: ;
      endcase
      if (m_req) begin
        if (m_retry == P_MR) m_nxt = 6;
        else begin m_retry++; m_nxt = 0; end
      end
    end
    m_cnt = (force_reset || m_nxt != m_st) ? 0 : m_cnt + 1;
    m_st  = m_nxt;
  endtask

  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge sys_clk);
    if (cmp_en) begin
      check("state",       32'(state),       32'(m_st));
      check("mmcm_rst",    32'(mmcm_rst),    32'(m_st == 0));
      check("idelay_rst",  32'(idelay_rst),  32'(m_st <= 3 || m_st == 6));
      check("rst_out",     32'(rst_out),     32'(m_st != 5));
      check("ready",       32'(ready),       32'(m_st == 5));
      check("fault",       32'(fault),       32'(m_st == 6));
      check("retry_count", 32'(retry_count), 32'(m_retry));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string nm);
    check({nm, "_state"},  32'(state),       32'd0);
    check({nm, "_mrst"},   32'(mmcm_rst),    32'd1);
    check({nm, "_irst"},   32'(idelay_rst),  32'd1);
    check({nm, "_rstout"}, 32'(rst_out),     32'd1);
    check({nm, "_ready"},  32'(ready),       32'd0);
    check({nm, "_fault"},  32'(fault),       32'd0);
    check({nm, "_retry"},  32'(retry_count), 32'd0);
  endtask

  task automatic pulse_force();
    force_reset = 1'b1;
    cyc();
    force_reset = 1'b0;
  endtask

  initial begin
    int f_mfall, f_ifall, f_rdy, f_fault, nfalls, k;
    int falls[4];
    bit prev_m;
    int flipdiv;

    // Reset state
    cyc(); cyc();
    cmp_en = 1'b1;
    check_reset_vals("reset");

    // Bring-up: lock 10 cycles after mmcm_rst falls, rdy 5 after idelay_rst falls
    @(negedge sys_clk); sys_rst = 1'b0;
    f_mfall = 0; f_ifall = 0; f_rdy = 0;
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (f_mfall == 0 && !mmcm_rst)   f_mfall = n;
      if (f_ifall == 0 && !idelay_rst) f_ifall = n;
      if (f_rdy == 0 && ready)         f_rdy = n;
      if (n == 14) mmcm_locked = 1'b1;
      if (n == 42) idelay_rdy = 1'b1;
    end
    check("bringup_mmcm_fall",   32'(f_mfall), 32'd4);
    check("bringup_idelay_fall", 32'(f_ifall), 32'd37);
    check("bringup_ready_cycle", 32'(f_rdy),   32'd45);
    check("bringup_rst_out",     32'(rst_out), 32'd0);
    check("bringup_retry",       32'(retry_count), 32'd0);

    // Run loss: rst_out reasserts 3 cycles after the mmcm_locked fall
    mmcm_locked = 1'b0;
    cyc(); check("runloss_hold1", 32'(ready), 32'd1);
    cyc(); check("runloss_hold2", 32'(ready), 32'd1);
    cyc();
    check("runloss_ready",  32'(ready),   32'd0);
    check("runloss_rstout", 32'(rst_out), 32'd1);
    check("runloss_state",  32'(state),   32'd0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mmcm_rst) break;
      k++;
      cyc();
    end
    check("runloss_pulse_width", 32'(k), 32'd4);
    mmcm_locked = 1'b1;
    wait_state(5, 200, "runloss_recover");
    check("runloss_retry", 32'(retry_count), 32'd0);

    // Glitch: lock drops at cycle 8 of STABLE
    pulse_force();
    wait_state(2, 60, "glitch_reach_stable");
    for (int i = 0; i < 7; i++) cyc();
    mmcm_locked = 1'b0;
    cyc();
    wait_state(0, 10, "glitch_to_reset");
    check("glitch_retry1", 32'(retry_count), 32'd1);
    mmcm_locked = 1'b1;
    wait_state(5, 200, "glitch_relock_run");
    check("glitch_retry0", 32'(retry_count), 32'd0);

    // force_reset and lock loss land on the same cycle
    pulse_force();
    wait_state(2, 60, "frc_reach_stable");
    mmcm_locked = 1'b0;
    cyc(); cyc();
    force_reset = 1'b1;
    cyc();
    force_reset = 1'b0;
    check("frc_state", 32'(state),       32'd0);
    check("frc_retry", 32'(retry_count), 32'd0);
    mmcm_locked = 1'b1;
    idelay_rdy  = 1'b0;

    // IDELAY hang: FAULT after 32 cycles in WAIT_IDELAY
    wait_state(4, 200, "hang_wait_idelay");
    k = 0;
    while (int'(state) == 4 && k < 100) begin k++; cyc(); end
    check("hang_cycles", 32'(k),     32'd32);
    check("hang_state",  32'(state), 32'd6);
    check("hang_fault",  32'(fault), 32'd1);
    pulse_force();
    check("hang_force_fault", 32'(fault), 32'd0);
    check("hang_force_state", 32'(state), 32'd0);
    wait_state(4, 200, "rerun_wait_idelay");
    cyc(); cyc(); cyc();

    // Async reset mid WAIT_IDELAY, observed before the next clock edge
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 check_reset_vals("async");
    @(negedge sys_clk); sys_rst = 1'b0;
    idelay_rdy = 1'b1;
    wait_state(5, 200, "async_recover");
    check("async_recover_rstout", 32'(rst_out), 32'd0);

    // No lock: three MMCM pulses then FAULT
    @(negedge sys_clk); sys_rst = 1'b1;
    mmcm_locked = 1'b0; idelay_rdy = 1'b0;
    cyc();
    @(negedge sys_clk); sys_rst = 1'b0;
    nfalls = 0; f_fault = 0; prev_m = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      cyc();
      if (prev_m && !mmcm_rst) begin
        if (nfalls < 4) falls[nfalls] = n;
        nfalls++;
      end
      prev_m = mmcm_rst;
      if (f_fault == 0 && fault) f_fault = n;
    end
    check("nolock_pulses", 32'(nfalls), 32'd3);
    check("nolock_fall0",  32'(falls[0]), 32'd4);
    check("nolock_fall1",  32'(falls[1]), 32'd40);
    check("nolock_fall2",  32'(falls[2]), 32'd76);
    check("nolock_fault_cycle", 32'(f_fault), 32'd108);
    check("nolock_state",  32'(state),       32'd6);
    check("nolock_retry",  32'(retry_count), 32'd2);

    // Randomized stimulus, checked every cycle by the model comparison
    mmcm_locked = 1'b1; idelay_rdy = 1'b1;
    pulse_force();
    flipdiv = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: flipdiv = 4;
          1: flipdiv = 40;
          default: flipdiv = 400;
        endcase
      end
      cyc();
      force_reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, flipdiv - 1) == 0) mmcm_locked = ~mmcm_locked;
      if (idelay_rdy) begin
        if ($urandom_range(0, 149) == 0) idelay_rdy = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        idelay_rdy = 1'b1;
      end
      if (sys_rst) sys_rst = 1'b0;
      else if ($urandom_range(0, 899) == 0) #1 sys_rst = 1'b1;
    end
    force_reset = 1'b0;
    sys_rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
